// File: rtl/svm_sched_pkg.sv
// Shared types and constants for the SVM batch scheduler: FSM states,
// conflict-type bit positions and the default-width batch entry layout.
package svm_sched_pkg;

  localparam int ID_W_DEF      = 64;
  localparam int ADDR_BITS_DEF = 256;
  localparam int MAX_BATCH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Bit positions inside the 3-bit conflict-type vector {WAR, WAW, RAW}.
  localparam int CT_RAW = 0;
  localparam int CT_WAW = 1;
  localparam int CT_WAR = 2;

  typedef struct packed {
    logic                     valid;
    logic [ID_W_DEF-1:0]      id;
    logic [ADDR_BITS_DEF-1:0] rd;
    logic [ADDR_BITS_DEF-1:0] wr;
  } entry_t;

endpackage

// File: rtl/svm_conflict_check.sv
// Combinational RAW/WAW/WAR compare of one candidate against every batch entry,
// followed by a lowest-index priority encoder selecting the blocking entry.
module svm_conflict_check
  import svm_sched_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int MAX_BATCH = MAX_BATCH_DEF,
  parameter int IDX_W     = $clog2(MAX_BATCH)
) (
  input  logic [ADDR_BITS-1:0]           cand_rd,
  input  logic [ADDR_BITS-1:0]           cand_wr,
  input  logic [MAX_BATCH-1:0]           ent_valid,
  input  logic [MAX_BATCH*ADDR_BITS-1:0] ent_rd,
  input  logic [MAX_BATCH*ADDR_BITS-1:0] ent_wr,
  output logic                           hit,
  output logic [IDX_W-1:0]               idx,
  output logic [2:0]                     ctype
);

  logic [2:0] flags [MAX_BATCH];

  always_comb begin
    for (int k = 0; k < MAX_BATCH; k++) begin
      flags[k]         = '0;
      flags[k][CT_RAW] = |(cand_rd & ent_wr[k*ADDR_BITS +: ADDR_BITS]);
      flags[k][CT_WAW] = |(cand_wr & ent_wr[k*ADDR_BITS +: ADDR_BITS]);
      flags[k][CT_WAR] = |(cand_wr & ent_rd[k*ADDR_BITS +: ADDR_BITS]);
      if (!ent_valid[k]) flags[k] = '0;
    end
  end

  // Scanning from the top down lets the lowest conflicting index win.
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    ctype = '0;
    for (int k = MAX_BATCH - 1; k >= 0; k--) begin
      if (|flags[k]) begin
        hit   = 1'b1;
        idx   = IDX_W'(k);
        ctype = flags[k];
      end
    end
  end

endmodule

// File: rtl/svm_batch_scheduler.sv
// Admits transactions into an open batch unless they conflict with an entry
// already in it; emits the batch downstream when full or on flush.
module svm_batch_scheduler
  import svm_sched_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int MAX_BATCH = MAX_BATCH_DEF,
  parameter int ID_W      = ID_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ID_W-1:0]                  in_id,
  input  logic [ADDR_BITS-1:0]             in_rd_set,
  input  logic [ADDR_BITS-1:0]             in_wr_set,
  output logic                             res_valid,
  output logic [ID_W-1:0]                  res_id,
  output logic                             res_accepted,
  output logic                             res_conflict,
  output logic [ID_W-1:0]                  res_conflict_id,
  output logic [2:0]                       res_conflict_type,
  input  logic                             batch_flush,
  output logic                             batch_valid,
  input  logic                             batch_ready,
  output logic [$clog2(MAX_BATCH+1)-1:0]   batch_count,
  output logic [MAX_BATCH*ID_W-1:0]        batch_ids,
  output logic [$clog2(MAX_BATCH+1)-1:0]   occupancy
);

  localparam int CNT_W = $clog2(MAX_BATCH + 1);
  localparam int IDX_W = $clog2(MAX_BATCH);

  typedef struct packed {
    logic                 valid;
    logic [ID_W-1:0]      id;
    logic [ADDR_BITS-1:0] rd;
    logic [ADDR_BITS-1:0] wr;
  } slot_t;

  state_e               state_q, state_d;
  slot_t                slot_q [MAX_BATCH];
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ID_W-1:0]      cand_id_q;
  logic [ADDR_BITS-1:0] cand_rd_q, cand_wr_q;
  logic                 out_en_q;

  logic                 res_valid_q, res_accepted_q, res_conflict_q;
  logic [ID_W-1:0]      res_id_q, res_conflict_id_q;
  logic [2:0]           res_conflict_type_q;

  logic                 flush_go, capture, accept, reject, drain_done;
  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;
  logic [2:0]           hit_type;

  logic [MAX_BATCH-1:0]           ent_valid;
  logic [MAX_BATCH*ADDR_BITS-1:0] ent_rd, ent_wr;

  always_comb begin
    ent_valid = '0;
    ent_rd    = '0;
    ent_wr    = '0;
    for (int k = 0; k < MAX_BATCH; k++) begin
      ent_valid[k]                       = slot_q[k].valid;
      ent_rd[k*ADDR_BITS +: ADDR_BITS]   = slot_q[k].rd;
      ent_wr[k*ADDR_BITS +: ADDR_BITS]   = slot_q[k].wr;
    end
  end

  svm_conflict_check #(
    .ADDR_BITS (ADDR_BITS),
    .MAX_BATCH (MAX_BATCH),
    .IDX_W     (IDX_W)
  ) u_check (
    .cand_rd   (cand_rd_q),
    .cand_wr   (cand_wr_q),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd),
    .ent_wr    (ent_wr),
    .hit       (hit),
    .idx       (hit_idx),
    .ctype     (hit_type)
  );

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the case statement infers a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    in_ready   = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    drain_done = 1'b0;
    flush_go   = batch_flush && (count_q != '0);
    unique case (state_q)
      S_IDLE: begin
        in_ready = out_en_q && !flush_go;
        if (flush_go) begin
          state_d = S_DRAIN;
        end else if (in_valid && in_ready) begin
          capture = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hit) begin
          reject  = 1'b1;
          state_d = S_IDLE;
        end else begin
          accept  = 1'b1;
          count_d = count_q + 1'b1;
          state_d = (count_q == CNT_W'(MAX_BATCH - 1)) ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (batch_ready) begin
          drain_done = 1'b1;
          count_d    = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // out_en_q keeps in_ready low while reset is asserted and for the first
  // cycle after release, so every output really is zero under reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      out_en_q  <= 1'b0;
      cand_id_q <= '0;
      cand_rd_q <= '0;
      cand_wr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      out_en_q <= 1'b1;
      if (capture) begin
        cand_id_q <= in_id;
        cand_rd_q <= in_rd_set;
        cand_wr_q <= in_wr_set;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q         <= 1'b0;
      res_id_q            <= '0;
      res_accepted_q      <= 1'b0;
      res_conflict_q      <= 1'b0;
      res_conflict_id_q   <= '0;
      res_conflict_type_q <= '0;
    end else begin
      res_valid_q <= accept || reject;
      if (accept || reject) begin
        res_id_q            <= cand_id_q;
        res_accepted_q      <= accept;
        res_conflict_q      <= reject;
        res_conflict_id_q   <= reject ? slot_q[hit_idx].id : '0;
        res_conflict_type_q <= reject ? hit_type : 3'b000;
      end
    end
  end

  // NOTE: the entry array is reset explicitly: a reset mid-drain must leave
  // no stale entry that could block the first transaction afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_BATCH; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < MAX_BATCH; k++) begin
        if (drain_done) begin
          slot_q[k] <= '0;
        end else if (accept && count_q == CNT_W'(k)) begin
          slot_q[k] <= '{valid: 1'b1, id: cand_id_q, rd: cand_rd_q, wr: cand_wr_q};
        end
      end
    end
  end

  always_comb begin
    batch_ids = '0;
    for (int k = 0; k < MAX_BATCH; k++) begin
      batch_ids[k*ID_W +: ID_W] = batch_valid ? slot_q[k].id : '0;
    end
  end

  assign batch_valid       = (state_q == S_DRAIN);
  assign batch_count       = batch_valid ? count_q : '0;
  assign occupancy         = count_q;
  assign res_valid         = res_valid_q;
  assign res_id            = res_id_q;
  assign res_accepted      = res_accepted_q;
  assign res_conflict      = res_conflict_q;
  assign res_conflict_id   = res_conflict_id_q;
  assign res_conflict_type = res_conflict_type_q;

endmodule

// File: tb/tb_svm_batch_scheduler.sv
// Self-checking bench for svm_batch_scheduler: directed scenarios followed by
// random traffic, all checked against a queue-based batch model.
module tb_svm_batch_scheduler;

  localparam int AB = 64;
  localparam int MB = 4;
  localparam int IW = 64;
  localparam int CW = $clog2(MB + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IW-1:0]     in_id = '0;
  logic [AB-1:0]     in_rd_set = '0;
  logic [AB-1:0]     in_wr_set = '0;
  logic              res_valid;
  logic [IW-1:0]     res_id;
  logic              res_accepted;
  logic              res_conflict;
  logic [IW-1:0]     res_conflict_id;
  logic [2:0]        res_conflict_type;
  logic              batch_flush = 1'b0;
  logic              batch_valid;
  logic              batch_ready = 1'b0;
  logic [CW-1:0]     batch_count;
  logic [MB*IW-1:0]  batch_ids;
  logic [CW-1:0]     occupancy;

  svm_batch_scheduler #(.ADDR_BITS(AB), .MAX_BATCH(MB), .ID_W(IW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_id             (in_id),
    .in_rd_set         (in_rd_set),
    .in_wr_set         (in_wr_set),
    .res_valid         (res_valid),
    .res_id            (res_id),
    .res_accepted      (res_accepted),
    .res_conflict      (res_conflict),
    .res_conflict_id   (res_conflict_id),
    .res_conflict_type (res_conflict_type),
    .batch_flush       (batch_flush),
    .batch_valid       (batch_valid),
    .batch_ready       (batch_ready),
    .batch_count       (batch_count),
    .batch_ids         (batch_ids),
    .occupancy         (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [AB-1:0] rd;
    logic [AB-1:0] wr;
  } txn_t;

  txn_t model_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [MB*IW-1:0] obs, input logic [MB*IW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AB-1:0] b(input int n);
    logic [AB-1:0] one = 1;
    return one << n;
  endfunction

  function automatic logic [AB-1:0] rand_set();
    logic [AB-1:0] s = '0;
    if ($urandom_range(0, 3) != 0) begin
      s = b($urandom_range(0, 11));
      if ($urandom_range(0, 1) == 1) s = s | b($urandom_range(0, 11));
    end
    return s;
  endfunction

  function automatic logic [MB*IW-1:0] exp_ids();
    logic [MB*IW-1:0] v = '0;
    foreach (model_q[k]) v[k*IW +: IW] = model_q[k].id;
    return v;
  endfunction

  // Offer one candidate, predict the verdict from the model, compare.
  task automatic submit(input logic [IW-1:0] id, input logic [AB-1:0] rd, input logic [AB-1:0] wr);
    int            waited = 0;
    logic          hit = 1'b0;
    logic [IW-1:0] cid = '0;
    logic [2:0]    ct = '0;
    logic          r, w, a;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_offer", in_ready, 1);
    in_valid = 1'b1; in_id = id; in_rd_set = rd; in_wr_set = wr;
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_during_check", in_ready, 0);
    foreach (model_q[k]) begin
      r = |(rd & model_q[k].wr);
      w = |(wr & model_q[k].wr);
      a = |(wr & model_q[k].rd);
      if (!hit && (r || w || a)) begin
        hit = 1'b1; cid = model_q[k].id; ct = {a, w, r};
      end
    end
    @(negedge clk);
    if (!hit) model_q.push_back('{id: id, rd: rd, wr: wr});
    check("res_valid", res_valid, 1);
    check("res_id", res_id, id);
    check("res_accepted", res_accepted, !hit);
    check("res_conflict", res_conflict, hit);
    check("res_conflict_id", res_conflict_id, cid);
    check("res_conflict_type", res_conflict_type, ct);
    check("occupancy", occupancy, model_q.size());
    if (model_q.size() == MB) begin
      check("full_batch_valid", batch_valid, 1);
      check("full_in_ready", in_ready, 0);
    end
  endtask

  // Hold the presented batch for 'hold' extra cycles, then take it.
  task automatic drain(input int hold);
    logic [MB*IW-1:0] ids = exp_ids();
    for (int i = 0; i <= hold; i++) begin
      check("drain_batch_valid", batch_valid, 1);
      check("drain_batch_count", batch_count, model_q.size());
      check("drain_batch_ids", batch_ids, ids);
      check("drain_in_ready", in_ready, 0);
      if (i < hold) @(negedge clk);
    end
    batch_ready = 1'b1;
    @(negedge clk);
    batch_ready = 1'b0;
    model_q.delete();
    check("post_drain_batch_valid", batch_valid, 0);
    check("post_drain_occupancy", occupancy, 0);
    check("post_drain_in_ready", in_ready, 1);
  endtask

  // Request a flush, optionally with a competing candidate that must wait.
  task automatic flush(input logic with_cand, input logic [IW-1:0] id,
                       input logic [AB-1:0] rd, input logic [AB-1:0] wr, input int hold);
    batch_flush = 1'b1;
    in_valid = with_cand; in_id = id; in_rd_set = rd; in_wr_set = wr;
    #1;
    check("flush_in_ready", in_ready, 0);
    @(negedge clk);
    batch_flush = 1'b0;
    drain(hold);
    if (with_cand) submit(id, rd, wr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #23 rst_n = 1'b1;
    @(negedge clk);
    check("reset_occupancy", occupancy, 0);
    check("reset_batch_valid", batch_valid, 0);
    check("reset_res_valid", res_valid, 0);

    // RAW
    submit(1, '0, b(5));
    submit(2, b(5), '0);
    check("raw_type_literal", res_conflict_type, 3'b001);
    @(negedge clk);
    check("res_valid_one_cycle", res_valid, 0);
    check("res_id_held", res_id, 2);

    // WAW then WAR
    submit(3, '0, b(10));
    submit(4, '0, b(10));
    check("waw_type_literal", res_conflict_type, 3'b010);
    submit(5, b(15), '0);
    submit(6, '0, b(15));
    check("war_type_literal", res_conflict_type, 3'b100);
    check("occupancy_three", occupancy, 3);

    // Full batch with backpressure
    submit(7, '0, '0);
    check("full_ids_literal", batch_ids, {64'd7, 64'd5, 64'd3, 64'd1});
    drain(3);
    submit(2, b(5), '0);

    // Flush priority over a simultaneous candidate
    flush(1'b0, '0, '0, '0, 0);
    submit(9, b(20), '0);
    flush(1'b1, 10, '0, b(30), 1);

    // Empty flush is ignored
    flush(1'b0, '0, '0, '0, 0);
    batch_flush = 1'b1;
    #1;
    check("empty_flush_in_ready", in_ready, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("empty_flush_batch_valid", batch_valid, 0);
      check("empty_flush_in_ready_hold", in_ready, 1);
    end
    batch_flush = 1'b0;

    // Reset in the middle of a drain
    for (int i = 0; i < MB; i++) submit(21 + i, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_batch_valid", batch_valid, 0);
    check("rst_batch_count", batch_count, 0);
    check("rst_batch_ids", batch_ids, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check("rst_in_ready", in_ready, 0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    submit(1, '0, b(5));

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0 && model_q.size() > 0) begin
        flush($urandom_range(0, 1) == 1, 100 + i, rand_set(), rand_set(), $urandom_range(0, 2));
      end else begin
        submit(100 + i, rand_set(), rand_set());
      end
      if (model_q.size() == MB) drain($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/svm_batch_scheduler.md
Name: svm_batch_scheduler

Overview:
Parametrised successor of the filter/insertion/batch pipeline. It accepts transactions, each an ID plus read-set and write-set bitmaps, and checks them for RAW, WAW and WAR conflicts against every transaction already admitted to the open batch. Non-conflicting transactions are appended to the batch. The batch is emitted over a valid/ready handshake when it is full or when a flush is requested. It sits between transaction intake and the executor dispatch.

Parameters:
ADDR_BITS, 256, width of each read/write dependency bitmap (one bit per account/address).
MAX_BATCH, 8, maximum transactions held in one batch (>=2).
ID_W, 64, transaction/program ID width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
in_valid  in  1  candidate transaction present.
in_ready  out  1  block can take a candidate this cycle.
in_id  in  ID_W  candidate program ID.
in_rd_set  in  ADDR_BITS  candidate read bitmap.
in_wr_set  in  ADDR_BITS  candidate write bitmap.
res_valid  out  1  one-cycle pulse: verdict for the last candidate.
res_id  out  ID_W  ID the verdict refers to.
res_accepted  out  1  candidate was appended to the batch.
res_conflict  out  1  candidate was rejected.
res_conflict_id  out  ID_W  ID of the blocking entry.
res_conflict_type  out  3  {WAR,WAW,RAW} flags vs the blocking entry.
batch_flush  in  1  request early emission of a non-empty batch.
batch_valid  out  1  batch presented downstream.
batch_ready  in  1  downstream takes the batch.
batch_count  out  $clog2(MAX_BATCH+1)  entries in the presented batch.
batch_ids  out  MAX_BATCH*ID_W  entry IDs; entry 0 at LSB; unused slots zero.
occupancy  out  $clog2(MAX_BATCH+1)  live entry count.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, every entry (id, rd, wr, valid) cleared, count=0, state IDLE. Reset mid-drain discards the batch.
- States:
  - IDLE: in_ready = !(batch_flush && count>0).
  - CHECK: in_ready=0.
  - DRAIN: in_ready=0.
- IDLE:
  - Flush request: if batch_flush=1 and count>0, go to DRAIN. Flush has priority over a simultaneous in_valid; the candidate waits.
  - Flush with count==0 is ignored.
  - Candidate capture: if in_valid && in_ready, latch id/rd/wr at this edge (E) and go to CHECK.
- CHECK, per valid entry k:
  - raw_k = |(cand_rd & wr_k)
  - waw_k = |(cand_wr & wr_k)
  - war_k = |(cand_wr & rd_k)
  - Blocking entry = lowest k with any flag set.
- At edge E+1, register the verdict:
  - res_valid=1, res_id=cand id.
  - On conflict: res_conflict=1, res_accepted=0, res_conflict_id=id_k, res_conflict_type={war_k,waw_k,raw_k}. The candidate is discarded.
  - Otherwise: res_accepted=1, conflict fields 0, candidate written to slot [count], count++.
- res_valid is high for exactly one cycle; the res_* fields hold their value until the next verdict.
- Throughput: one candidate per 2 cycles. Verdict latency: 1 cycle after capture.
- A candidate with empty rd and wr sets never conflicts. Bits set in both the rd and wr sets of one candidate are legal; there is no self-conflict check.
- Full: if the append makes count==MAX_BATCH, go directly to DRAIN; otherwise return to IDLE. In IDLE, count<MAX_BATCH always holds.
- DRAIN:
  - batch_valid=1, with batch_count/batch_ids registered and stable until the handshake.
  - On batch_valid && batch_ready: clear all entries, count=0, batch_valid=0, go to IDLE (in_ready high next cycle).
  - batch_flush is ignored in DRAIN.
- occupancy = count at all times.
- Width rules: count saturates by construction. The priority encoder is sized $clog2(MAX_BATCH).

Decomposition:
- Package svm_sched_pkg holds:
  - ID_W default constant;
  - state enum (IDLE, CHECK, DRAIN);
  - conflict-type bit positions (RAW=0, WAW=1, WAR=2);
  - entry struct {valid, id, rd, wr} parametrised via localparams.
- Sub-module svm_conflict_check: combinational compare of the candidate against all entries, plus the lowest-index priority encoder. Outputs hit, idx, type.

Test Plan (ADDR_BITS=64, MAX_BATCH=4):
1. RAW: id 1 wr bit5 -> accepted, occupancy 1. Then id 2 rd bit5 -> res_conflict=1, res_conflict_id=1, type=3'b001, occupancy stays 1.
2. WAW then WAR: id 3 wr bit10 accepted; id 4 wr bit10 -> conflict id 3, type 3'b010. id 5 rd bit15 accepted; id 6 wr bit15 -> conflict id 5, type 3'b100. Occupancy 3.
3. Full + backpressure: id 7 with empty sets accepted -> DRAIN, batch_valid=1, batch_count=4, batch_ids={7,5,3,1}, in_ready=0. Hold batch_ready=0 for 3 cycles -> outputs stable. Assert batch_ready -> occupancy 0. Resubmit id 2 rd bit5 -> accepted.
4. Flush priority: one entry (id 9) held; drive batch_flush=1 together with in_valid (id 10) -> in_ready=0, batch_count=1, batch_ids slot0=9, other slots 0. After the handshake, id 10 is captured.
5. Empty flush: occupancy 0, batch_flush=1 for 2 cycles -> batch_valid stays 0, in_ready stays 1.
6. Reset mid-drain: during batch_valid=1, pulse rst_n low off-clock-edge -> all outputs 0 immediately, occupancy 0. After release, id 1 wr bit5 is accepted with no stale conflict.
